// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared arbiter types, defaults and helpers
package noc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    // Bits needed to index `value` items; used for pointer/owner widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signal bundle
interface fifo_wr_arbiter_if
    import noc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);
    localparam int PW = clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   tail;
    logic [N*W-1:0] item;
    logic [N-1:0]   gnt;
    logic           write;
    logic [W-1:0]   item_out;
    logic           full;
    logic           busy;
    logic [PW-1:0]  owner;

    modport slave (
        input  req, tail, item, full,
        output gnt, write, item_out, busy, owner
    );

    modport master (
        output req, tail, item, full,
        input  gnt, write, item_out, busy, owner
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority picker
module rr_pick
    import noc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] sel,
    output logic          any
);

    logic [31:0] idx;

    // Scan ptr, ptr+1, ... wrapping modulo N; the first requester seen wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= 32'(N)) begin
                idx = idx - 32'(N);
            end
            if (!any && req[idx[PW-1:0]]) begin
                any = 1'b1;
                sel = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-aware round-robin arbiter for a FIFO write port
module fifo_wr_arbiter
    import noc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam int PW = clog2(N);

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;

    logic [PW-1:0] pick_sel;
    logic          pick_any;
    logic [PW-1:0] sel;
    logic          req_sel;
    logic          tail_sel;
    logic          valid;
    logic          acc;
    logic [W-1:0]  item_sel;

    // Next round-robin start position after index v, wrapping at N-1.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] v);
        if (v == PW'(N - 1)) begin
            return '0;
        end
        return v + PW'(1);
    endfunction

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Selection, acceptance gating, write-port outputs and next state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        req_sel  = 1'b0;
        tail_sel = 1'b0;
        item_sel = '0;
        bus.gnt  = '0;

        // A locked packet keeps the port even while its owner is idle (bubble).
        sel = (state_q == ST_LOCK) ? owner_q : pick_sel;

        for (int i = 0; i < N; i++) begin
            if (sel == PW'(i)) begin
                req_sel  = bus.req[i];
                tail_sel = bus.tail[i];
                item_sel = bus.item[i*W +: W];
            end
        end

        valid = (state_q == ST_LOCK) ? req_sel : pick_any;
        // Reset low forces the strobe off even though it is not registered.
        acc   = valid && !bus.full && reset;

        for (int i = 0; i < N; i++) begin
            bus.gnt[i] = acc && (sel == PW'(i));
        end
        bus.write    = acc;
        bus.item_out = item_sel;

        if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    owner_d = sel;
                    if (tail_sel) begin
                        ptr_d = next_ptr(sel);
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (tail_sel) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_ptr(owner_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, round-robin pointer and owner registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign bus.busy  = (state_q == ST_LOCK);
    assign bus.owner = owner_q;

endmodule
